// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the display board UART (uart_tx, uart_rx).
//   - uart_state_t : transmitter/receiver frame state encoding
//   - CLKS_PER_BIT_DEFAULT : 100 MHz / 115200 baud, truncated
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick_gen.sv
// baud_tick_gen: free-running bit-period counter.
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   en   : count enable; counter is held at zero while low
//   tick : one-cycle pulse when the counter sits at CLKS_PER_BIT-1
// The counter wraps to zero on the tick cycle, so consecutive ticks are
// exactly CLKS_PER_BIT cycles apart while en stays high.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt <= '0;
        end else if (cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == TC);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, 8N1/8N2 (8E1/8E2 with parity).
//   clk      : system clock, 100 MHz
//   rst      : synchronous, active-low reset
//   tx_data  : byte to send, captured on handshake
//   tx_valid : producer has a byte on tx_data
//   tx_ready : transmitter accepts a byte this cycle (registered)
//   txd      : serial line, idle high (registered)
//   busy     : high from the cycle after handshake until the last stop bit ends
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits. The port list is the same in both builds.
//
// state  | meaning
// IDLE   | line high, tx_ready asserted, waiting for handshake
// START  | start bit (txd=0) for one bit period
// DATA   | 8 data bits, LSB first, shift register drives txd
// PARITY | even parity bit for one bit period (parity build only)
// STOP   | txd=1 for STOP_BITS bit periods, then back to IDLE
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    // bit_cnt also counts stop bits, so the last stop index must fit in 3 bits
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_state_t state, state_next;
    logic [7:0]  shift, shift_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic        txd_next;
    logic        tick;
    logic        handshake;

`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    assign handshake = tx_valid && tx_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;

        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next   = START;
                    shift_next   = tx_data;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift >> 1;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // txd is registered: decode the level the line must show next cycle
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = parity_bit;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            tx_ready <= 1'b0;
        end else begin
            state    <= state_next;
            shift    <= shift_next;
            bit_cnt  <= bit_cnt_next;
            txd      <= txd_next;
            tx_ready <= (state_next == IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_bit <= 1'b0;
        end else if (state == IDLE && handshake) begin
            parity_bit <= ^tx_data;
        end
    end
`endif

endmodule
